// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: frame geometry constants and the lock FSM state type shared by
// the I2S DAC transmitter and its lock qualifier.
package i2s_tx_pkg;

  localparam int MCLK_PER_BCLK = 4;
  localparam int SLOT_BITS     = 32;
  localparam int FRAME_MCLKS   = 256;

  // Derived geometry: frame counter width, the counter bit that is BCLK,
  // and the width of the slot bit index taken from the counter's upper bits.
  localparam int FC_W     = $clog2(FRAME_MCLKS);
  localparam int BCLK_BIT = $clog2(MCLK_PER_BCLK) - 1;
  localparam int BI_W     = FC_W - BCLK_BIT - 1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    QUALIFY  = 2'd1,
    RUN      = 2'd2
  } lock_state_t;

endpackage

// File: rtl/i2s_lock_qual.sv
// i2s_lock_qual: synchronises the PLL lock flag, requires it to stay high for
// LOCK_WAIT consecutive cycles, and reports when the transmitter may run.
// o_run_nxt is the state the FSM takes at the coming edge, so the datapath
// can clear or start in the same cycle that o_running changes.
module i2s_lock_qual
  import i2s_tx_pkg::*;
#(
  parameter int LOCK_WAIT = 1024
)(
  input  logic clk,
  input  logic rst,
  input  logic i_pll_locked,
  output logic o_running,
  output logic o_run_nxt
);

  localparam int               CNT_W    = $clog2(LOCK_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             r_sync1;
  logic             r_lock_s;
  logic [CNT_W-1:0] r_cnt;
  lock_state_t      r_state;
  lock_state_t      w_state_nxt;

  // Two-flop synchroniser: the lock flag has no timing relation to MCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= i_pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= UNLOCKED;
    else     r_state <= w_state_nxt;
  end

  // Next state: any loss of lock drops straight back to UNLOCKED.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UNLOCKED: if (r_lock_s) w_state_nxt = QUALIFY;
      QUALIFY: begin
        if (!r_lock_s)              w_state_nxt = UNLOCKED;
        else if (r_cnt == CNT_LAST) w_state_nxt = RUN;
      end
      RUN:      if (!r_lock_s) w_state_nxt = UNLOCKED;
      default:  w_state_nxt = UNLOCKED;
    endcase
  end

  // Qualify counter advances only in QUALIFY and sits at zero elsewhere, so every qualification starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_cnt <= '0;
    else if (r_state != QUALIFY)           r_cnt <= '0;
    else if (r_lock_s)                     r_cnt <= r_cnt + CNT_W'(1);
  end

  // Outputs decoded from the registered state and its successor.
  always_comb begin
    o_running = (r_state == RUN);
    o_run_nxt = (w_state_nxt == RUN);
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: stereo I2S transmitter clocked by MCLK. BCLK = MCLK/4 and
// LRCLK = MCLK/256 come from an 8-bit frame counter; each frame carries one
// left/right pair, MSB-first and left-justified in 32-bit slots, delayed one
// BCLK after the LRCLK edge. Pairs arrive over valid/ready into a one-deep
// holding register and are moved into the frame registers at fc = 255.
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN adds a 16-bit saturating
// underrun_count output.
module i2s_dac_tx
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_W  = 24,
  parameter int LOCK_WAIT = 1024
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_ready,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                running
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_count
`endif
);

  localparam logic [6:0] L_LAST  = 7'(SAMPLE_W);
  localparam logic [6:0] R_FIRST = 7'(SLOT_BITS + 1);
  localparam logic [6:0] R_LAST  = 7'(SLOT_BITS + SAMPLE_W);

  logic                w_running;
  logic                w_run_nxt;
  logic                w_hold_run;
  logic [FC_W-1:0]     r_fc;
  logic [FC_W-1:0]     w_fc_nxt;
  logic [BI_W-1:0]     w_bi_nxt;
  logic                w_reload;
  logic                w_accept;
  logic                r_full;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic [SAMPLE_W-1:0] r_frm_l;
  logic [SAMPLE_W-1:0] r_frm_r;
  logic [SAMPLE_W-1:0] w_frm_l_nxt;
  logic [SAMPLE_W-1:0] w_frm_r_nxt;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_dat;

  // Serial data bit for slot index bi: one idle bit, then the sample MSB-first, then zeros.
  function automatic logic slot_bit(input logic [BI_W-1:0]     bi,
                                    input logic [SAMPLE_W-1:0] l,
                                    input logic [SAMPLE_W-1:0] r);
    logic [6:0]          b;
    logic [SAMPLE_W-1:0] sh;
    b        = 7'(bi);
    sh       = '0;
    slot_bit = 1'b0;
    if (b >= 7'd1 && b <= L_LAST) begin
      sh       = l << (b - 7'd1);
      slot_bit = sh[SAMPLE_W-1];
    end else if (b >= R_FIRST && b <= R_LAST) begin
      sh       = r << (b - R_FIRST);
      slot_bit = sh[SAMPLE_W-1];
    end
  endfunction

  // Word select leads the data by one BCLK, so it is high for slot bits 31..62.
  function automatic logic word_sel(input logic [BI_W-1:0] bi);
    word_sel = (bi >= BI_W'(SLOT_BITS - 1)) && (bi <= BI_W'(2 * SLOT_BITS - 2));
  endfunction

  i2s_lock_qual #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qual (
    .clk          (clk),
    .rst          (rst),
    .i_pll_locked (pll_locked),
    .o_running    (w_running),
    .o_run_nxt    (w_run_nxt)
  );

  // Next frame position and the frame registers that position reads from; the reload happens at fc = 255.
  always_comb begin
    w_hold_run  = w_running & w_run_nxt;
    w_fc_nxt    = r_fc + FC_W'(1);
    w_bi_nxt    = w_fc_nxt[FC_W-1:BCLK_BIT+1];
    w_reload    = (r_fc == FC_W'(FRAME_MCLKS - 1));
    w_accept    = sample_valid & sample_ready;
    w_frm_l_nxt = r_frm_l;
    w_frm_r_nxt = r_frm_r;
    if (w_reload) begin
      w_frm_l_nxt = r_full ? r_hold_l : '0;
      w_frm_r_nxt = r_full ? r_hold_r : '0;
    end
  end

  // Frame counter, frame registers and registered serial outputs; all clear unless RUN holds across the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc    <= '0;
      r_frm_l <= '0;
      r_frm_r <= '0;
      r_bclk  <= 1'b0;
      r_lrck  <= 1'b0;
      r_dat   <= 1'b0;
    end else if (!w_hold_run) begin
      r_fc    <= '0;
      r_frm_l <= '0;
      r_frm_r <= '0;
      r_bclk  <= 1'b0;
      r_lrck  <= 1'b0;
      r_dat   <= 1'b0;
    end else begin
      r_fc    <= w_fc_nxt;
      r_frm_l <= w_frm_l_nxt;
      r_frm_r <= w_frm_r_nxt;
      r_bclk  <= w_fc_nxt[BCLK_BIT];
      r_lrck  <= word_sel(w_bi_nxt);
      r_dat   <= slot_bit(w_bi_nxt, w_frm_l_nxt, w_frm_r_nxt);
    end
  end

  // Holding register: one pair waiting for the next frame boundary; discarded whenever RUN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (!w_hold_run) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (w_accept) begin
      r_full   <= 1'b1;
      r_hold_l <= sample_left;
      r_hold_r <= sample_right;
    end else if (w_reload) begin
      r_full   <= 1'b0;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun;

  // Counts frame boundaries that found no pair waiting; the zero frame at RUN entry is not a reload and never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_underrun <= '0;
    else if (w_hold_run && w_reload && !r_full && r_underrun != 16'hFFFF)
      r_underrun <= r_underrun + 16'd1;
  end

  assign underrun_count = r_underrun;
`endif

  assign sample_ready = w_running & ~r_full;
  assign aud_bclk     = r_bclk;
  assign aud_daclrck  = r_lrck;
  assign aud_dacdat   = r_dat;
  assign running      = w_running;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized bench for i2s_dac_tx. A frame-level model keeps
// the pair due in the next frame and builds the expected 64-bit slot image
// by concatenation; the bench samples DATA/LRCLK at each BCLK rising edge.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  localparam int          SW       = 24;
  localparam int          LW       = 1024;
  localparam int          LOCK_LAT = LW + 3;
  localparam logic [63:0] LR_PAT   = {31'h0, 32'hFFFF_FFFF, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          sample_valid;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;
  logic          sample_ready;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
  logic          running;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  int            n_cmp = 0;
  int            n_fail = 0;
  logic          m_has;
  logic [SW-1:0] m_l, m_r;
  int            m_underruns = 0;
  logic [SW-1:0] g_l, g_r;

  i2s_dac_tx #(.SAMPLE_W(SW), .LOCK_WAIT(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sample_valid (sample_valid),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .running      (running)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Slot image of a frame as transmitted, MSB = slot bit 0.
  function automatic logic [63:0] exp_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
  endfunction

  // Counts cycles from now until running is seen high; -1 if it never comes.
  task automatic wait_running(output int n);
    n = -1;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (running === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Runs one frame from the negedge at fc = 0. mode 0: no offer, 1: one pair at offer_k, 2: valid held with a counting stream.
  task automatic run_frame(input int mode, input logic [SW-1:0] l, input logic [SW-1:0] r, input int offer_k,
                           output logic [63:0] db, output logic [63:0] lb, output logic [63:0] ex,
                           output int bad, output int nacc, output logic [SW-1:0] al, output logic [SW-1:0] ar);
    logic pend;
    pend = 1'b0; bad = 0; nacc = 0; al = '0; ar = '0; db = '0; lb = '0;
    ex = m_has ? exp_frame(m_l, m_r) : 64'd0;
    if (mode == 0) sample_valid = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mode == 1 && k == offer_k) begin
        sample_valid = 1'b1; sample_left = l; sample_right = r;
      end
      if (mode == 2) begin
        sample_valid = 1'b1; sample_left = g_l; sample_right = g_r;
      end
      if (aud_bclk !== ((k % 4) >= 2)) bad++;
      if (running !== 1'b1) bad++;
      if (k % 4 == 2) begin
        db[63 - k / 4] = aud_dacdat;
        lb[63 - k / 4] = aud_daclrck;
      end
      if (sample_valid && sample_ready) begin
        pend = 1'b1; nacc++; al = sample_left; ar = sample_right;
      end
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (mode == 2) begin
          g_l = g_l + 1'b1; g_r = g_r + 1'b1;
          sample_left = g_l; sample_right = g_r;
        end else begin
          sample_valid = 1'b0;
        end
      end
    end
    if (mode != 2) sample_valid = 1'b0;
    if (nacc == 0) m_underruns++;
    m_has = (nacc > 0); m_l = al; m_r = ar;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; sample_valid = 1'b0; sample_left = '0; sample_right = '0;
    repeat (4) @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++; if (aud_bclk !== 1'b0) begin n_fail++; $display("FAIL reset_bclk: got %b want 0", aud_bclk); end
    n_cmp++; if (aud_daclrck !== 1'b0) begin n_fail++; $display("FAIL reset_lrck: got %b want 0", aud_daclrck); end
    n_cmp++; if (aud_dacdat !== 1'b0) begin n_fail++; $display("FAIL reset_dat: got %b want 0", aud_dacdat); end
    n_cmp++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", sample_ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d want 0", underrun_count); end
`endif
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_qual();
    int n, bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar;
    repeat (4) @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL idle_unlocked: got %b want 0", running); end
    pll_locked = 1'b1;
    wait_running(n);
    n_cmp++; if (n != LOCK_LAT) begin n_fail++; $display("FAIL lock_latency: got %0d want %0d", n, LOCK_LAT); end
    m_has = 1'b0;
    run_frame(1, 24'hABCDEF, 24'h123456, $urandom_range(200, 0), db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== 64'd0) begin n_fail++; $display("FAIL first_frame_zero: got %h want 0", db); end
    n_cmp++; if (lb !== LR_PAT) begin n_fail++; $display("FAIL first_frame_lrck: got %h want %h", lb, LR_PAT); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL first_frame_bclk: got %0d errors want 0", bad); end
    n_cmp++; if (nacc != 1) begin n_fail++; $display("FAIL first_frame_accepts: got %0d want 1", nacc); end
  endtask

  task automatic test_serial_data();
    int bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar, l, r;
    run_frame(0, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== exp_frame(24'hABCDEF, 24'h123456)) begin
      n_fail++; $display("FAIL serial_known: got %h want %h", db, exp_frame(24'hABCDEF, 24'h123456)); end
    n_cmp++; if (lb !== LR_PAT) begin n_fail++; $display("FAIL serial_lrck: got %h want %h", lb, LR_PAT); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL serial_bclk: got %0d errors want 0", bad); end
    for (int f = 0; f < 4; f++) begin
      l = SW'($urandom); r = SW'($urandom);
      if (f == 0) begin l = 24'h800001; r = 24'h7FFFFE; end
      run_frame((f == 3) ? 0 : 1, l, r, $urandom_range(200, 0), db, lb, ex, bad, nacc, al, ar);
      n_cmp++; if (db !== ex) begin n_fail++; $display("FAIL serial_rand%0d: got %h want %h", f, db, ex); end
      n_cmp++; if (nacc != ((f == 3) ? 0 : 1)) begin n_fail++; $display("FAIL serial_acc%0d: got %0d", f, nacc); end
    end
  endtask

  task automatic test_back_to_back();
    int bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar, prev, want;
    g_l = SW'($urandom); g_r = SW'($urandom);
    prev = '0;
    for (int f = 0; f < 5; f++) begin
      run_frame(2, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
      n_cmp++; if (db !== ex) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", f, db, ex); end
      n_cmp++; if (nacc != 1) begin n_fail++; $display("FAIL b2b_accepts%0d: got %0d want 1", f, nacc); end
      if (f > 0) begin
        want = prev + 1'b1;
        n_cmp++; if (al !== want) begin n_fail++; $display("FAIL b2b_seq%0d: got %h want %h", f, al, want); end
      end
      prev = al;
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_underrun();
    int bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] u0, du;
    u0 = underrun_count;
`endif
    run_frame(0, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== ex) begin n_fail++; $display("FAIL underrun_last: got %h want %h", db, ex); end
    run_frame(0, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== 64'd0) begin n_fail++; $display("FAIL underrun_frameA: got %h want 0", db); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    du = underrun_count - u0;
    n_cmp++; if (du !== 16'd2) begin n_fail++; $display("FAIL underrun_delta: got %0d want 2", du); end
`endif
    run_frame(1, SW'($urandom), SW'($urandom), $urandom_range(200, 0), db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== 64'd0) begin n_fail++; $display("FAIL underrun_frameB: got %h want 0", db); end
    n_cmp++; if (lb !== LR_PAT) begin n_fail++; $display("FAIL underrun_lrck: got %h want %h", lb, LR_PAT); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_count !== 16'(m_underruns)) begin
      n_fail++; $display("FAIL underrun_total: got %0d want %0d", underrun_count, m_underruns); end
`endif
  endtask

  task automatic test_midframe_loss();
    int n, bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar;
    logic [4:0] outs;
    sample_valid = 1'b1; sample_left = SW'($urandom); sample_right = SW'($urandom);
    @(negedge clk);
    sample_valid = 1'b0;
    n_cmp++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL loss_held: got ready %b want 0", sample_ready); end
    repeat (99) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    outs = {running, aud_bclk, aud_daclrck, aud_dacdat, sample_ready};
    n_cmp++; if (outs !== 5'd0) begin n_fail++; $display("FAIL loss_outputs: got %b want 00000", outs); end
    pll_locked = 1'b1;
    wait_running(n);
    n_cmp++; if (n != LOCK_LAT) begin n_fail++; $display("FAIL relock_latency: got %0d want %0d", n, LOCK_LAT); end
    m_has = 1'b0;
    run_frame(1, SW'($urandom), SW'($urandom), $urandom_range(200, 0), db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== 64'd0) begin n_fail++; $display("FAIL relock_first_zero: got %h want 0", db); end
    n_cmp++; if (nacc != 1) begin n_fail++; $display("FAIL relock_accepts: got %0d want 1", nacc); end
    run_frame(0, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== ex) begin n_fail++; $display("FAIL relock_new_pair: got %h want %h", db, ex); end
  endtask

  task automatic test_lock_glitch();
    int n, bad, nacc;
    logic [63:0] db, lb, ex;
    logic [SW-1:0] al, ar;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL glitch_drop: got %b want 0", running); end
    pll_locked = 1'b1;
    repeat (503) @(negedge clk);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL glitch_qualifying: got %b want 0", running); end
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    wait_running(n);
    n_cmp++; if (n != LOCK_LAT) begin n_fail++; $display("FAIL glitch_restart: got %0d want %0d", n, LOCK_LAT); end
    m_has = 1'b0;
    run_frame(1, SW'($urandom), SW'($urandom), $urandom_range(200, 0), db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== 64'd0) begin n_fail++; $display("FAIL glitch_first_zero: got %h want 0", db); end
    run_frame(0, '0, '0, -1, db, lb, ex, bad, nacc, al, ar);
    n_cmp++; if (db !== ex) begin n_fail++; $display("FAIL glitch_data: got %h want %h", db, ex); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL glitch_bclk: got %0d errors want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_lock_qual();
    test_serial_data();
    test_back_to_back();
    test_underrun();
    test_midframe_loss();
    test_lock_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Stereo I2S transmitter driven by the 12.288 MHz audio PLL output clock (MCLK). Generates BCLK (3.072 MHz) and LRCLK (48 kHz) by division and serialises 24-bit left/right samples to the audio codec DAC pin. Takes samples from the upstream sample source over a valid/ready handshake. Stays silent until the PLL `locked` signal has been stable for a qualification period.

## Interface
- `SAMPLE_W`, 24: sample width per channel, 1..32, MSB-first, left-justified in a 32-bit slot.
- `LOCK_WAIT`, 1024: consecutive synchronised-locked MCLK cycles required before transmission starts, ≥2.
- `clk` in 1: MCLK, 12.288 MHz, from the audio PLL output; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `sample_valid` in 1: a left/right pair is offered.
- `sample_left` in SAMPLE_W: left sample, two's complement.
- `sample_right` in SAMPLE_W: right sample, two's complement.
- `sample_ready` out 1: holding register empty; the pair is accepted on `sample_valid & sample_ready`.
- `aud_bclk` out 1: bit clock, MCLK/4.
- `aud_daclrck` out 1: word select; 0 = left, 1 = right.
- `aud_dacdat` out 1: serial data.
- `running` out 1: transmitter is in RUN.

## Operation
- Lock path: 2-flop synchroniser on `pll_locked` → `lock_s`.
- FSM states:
  - UNLOCKED: `lock_s = 1` → QUALIFY; clear the qualify counter.
  - QUALIFY: count up while `lock_s = 1`; `lock_s = 0` → UNLOCKED; count reaches `LOCK_WAIT-1` → RUN.
  - RUN: `lock_s = 0` → UNLOCKED, effective the next cycle.
- Outside RUN, or on leaving RUN mid-frame:
  - `aud_bclk`, `aud_daclrck`, `aud_dacdat`, `sample_ready` and `running` are driven 0.
  - Frame counter, shift registers and holding register are cleared; any pending pair is discarded.
- Frame counter `fc[7:0]`: reset to 0 on RUN entry; increments every cycle in RUN; wraps 255 → 0, giving 256 MCLK per frame.
- Slot bit index `bi = fc[7:2]`, range 0..63.
- `aud_bclk = fc[1]`: low for fc mod 4 ∈ {0,1}, high for {2,3}. Falls when fc mod 4 = 0.
- `aud_daclrck`: 0 for bi ∈ {63, 0..30}, 1 for bi ∈ 31..62. It changes one BCLK before the first data bit, per I2S.
- `aud_dacdat`:
  - left bit `SAMPLE_W-bi` for bi = 1..SAMPLE_W;
  - right bit `SAMPLE_W-(bi-32)` for bi = 33..32+SAMPLE_W;
  - 0 for all other bi.
  - Updates only when fc mod 4 = 0.
- Holding register: one pair plus a full flag.
  - `sample_ready = running & ~full`.
  - Handshake acceptance sets full.
- Frame reload when fc = 255, into the frame registers used from fc = 0:
  - If full: load the held pair and clear full. An acceptance in the same cycle is impossible because `ready = 0`.
  - If empty: underrun; load zeros.
- The first frame after RUN entry always outputs zeros.

## Timing
- All outputs are registered and reflect the new `fc` value in the cycle `fc` takes it, so the BCLK falling edge and the data change coincide.
- Reset values: all outputs 0; FSM UNLOCKED.
- Lock latency: `pll_locked` rise → `running` = 1 after 2 sync cycles + `LOCK_WAIT` cycles + 1.
- Lock loss: `pll_locked` fall → outputs 0 within 3 cycles.
- Sample latency: a pair accepted at any time during frame N is transmitted in frame N+1. Its left MSB appears at fc = 4 of that frame.
- Throughput: at most one pair per 256 cycles. `sample_ready` rises the cycle after the fc = 255 reload.
- `sample_valid` may be held high indefinitely. The source must not change data while `valid & ~ready`.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - Adds output `underrun_count`, 16 bits.
  - Increments on each empty reload in RUN, except the first frame after RUN entry; saturates at 0xFFFF.
  - Cleared by `rst` only.
- Undefined: the port and counter are absent; underrun behaviour is otherwise identical.

## Structure
- Package `i2s_tx_pkg` holds:
  - constants `MCLK_PER_BCLK = 4`, `SLOT_BITS = 32`, `FRAME_MCLKS = 256`;
  - the FSM state enum: UNLOCKED, QUALIFY, RUN.
- One sub-module, `i2s_lock_qual`, contains the synchroniser, qualify counter and FSM, and outputs `running`.

## Test plan
- Lock qualification: `rst` released, `pll_locked` = 1 → `running` rises exactly 2 + 1024 + 1 cycles later; the first frame outputs `aud_dacdat` = 0 throughout.
- Serial data: offer L = 0xABCDEF, R = 0x123456 during frame 0. In frame 1, `aud_dacdat` sampled on BCLK rising edges gives 0, then 0xABCDEF MSB-first, then zeros; LRCLK rises at bi = 31; then 0, 0x123456, zeros.
- Back-to-back: `sample_valid` held high with an incrementing pattern → exactly one acceptance per 256 cycles; consecutive frames carry consecutive values with no gaps.
- Underrun: withhold `sample_valid` for frames 2–3 → both frames all zero; `underrun_count` = 2 when the macro is defined.
- Lock glitch: `pll_locked` low for 5 cycles during QUALIFY at count 500 → the counter restarts; `running` is delayed accordingly.
- Mid-frame loss: drop `pll_locked` at fc = 100 with a pair held → all outputs 0 within 3 cycles; after relock and requalification, the first frame is zeros and the old pair is not sent.
